// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Constants and types shared by the FIR coefficient loader, its tap bank and
//   the FIR datapath that consumes the active taps.
//
//   TAP_WIDTH   : bits per coefficient (signed two's complement)
//   TAP_COUNT   : taps per frame (must be >= 2)
//   DEFAULT_TAP : value every active tap takes while in reset
//   tap_idx_t   : index into the tap bank, wide enough for TAP_COUNT-1
//   loader_state_t : loader FSM states
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int TAP_WIDTH = 16;
  localparam int TAP_COUNT = 50;
  localparam logic [TAP_WIDTH-1:0] DEFAULT_TAP = 16'h0021;

  localparam int IDX_WIDTH = $clog2(TAP_COUNT);

  typedef logic [IDX_WIDTH-1:0] tap_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } loader_state_t;

endpackage

// File: rtl/fir_tap_bank.sv
// -----------------------------------------------------------------------------
// fir_tap_bank
//   Shadow/active register pair for the FIR taps. The shadow bank is written one
//   tap at a time by the loader; the active bank is replaced by the whole shadow
//   bank in a single edge when swap is asserted, so downstream logic never sees
//   a partially written tap set.
//
//   Ports
//     clk       : clock, rising edge
//     reset_n   : asynchronous active-low reset (shadow = 0, active = RESET_VAL)
//     wr_en     : write wr_data into shadow[wr_idx]
//     wr_idx    : shadow tap index
//     wr_data   : coefficient value, stored bit-exact
//     swap      : copy the full shadow bank into the active bank
//     taps_flat : active taps, tap k at [k*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module fir_tap_bank #(
  parameter int                WIDTH     = fir_pkg::TAP_WIDTH,
  parameter int                COUNT     = fir_pkg::TAP_COUNT,
  parameter logic [WIDTH-1:0]  RESET_VAL = fir_pkg::DEFAULT_TAP
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(COUNT)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     swap,
  output logic [COUNT*WIDTH-1:0]   taps_flat
);

  logic [WIDTH-1:0] shadow [COUNT];
  logic [WIDTH-1:0] active [COUNT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < COUNT; k++) begin
        shadow[k] <= '0;
        active[k] <= RESET_VAL;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_idx] <= wr_data;
      end
      // The loader never writes and swaps in the same cycle (it is not
      // accepting beats while waiting for the swap), so reading the shadow
      // here always sees a complete frame.
      if (swap) begin
        for (int k = 0; k < COUNT; k++) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  always_comb begin
    taps_flat = '0;
    for (int k = 0; k < COUNT; k++) begin
      taps_flat[k*WIDTH +: WIDTH] = active[k];
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//   Writer side of the FIR tap bank. Receives a framed coefficient stream,
//   checks that each frame carries exactly TAP_COUNT beats, and hands a
//   complete frame to the active bank only on a filter sample boundary.
//
//   Handshake: a beat transfers on a rising edge where coef_valid and
//   coef_ready are both high. coef_ready is a registered decode of the next
//   state (high in IDLE/LOAD, low in WAIT_SWAP) and never depends
//   combinationally on coef_valid. The source holds data/last stable while
//   valid is high and ready is low.
//
//   Ports
//     clk, reset_n  : clock (rising edge), asynchronous active-low reset
//     coef_valid    : beat valid
//     coef_ready    : loader can accept a beat
//     coef_data     : coefficient; beat k of a frame targets tap k
//     coef_last     : final beat of a frame
//     load_abort    : synchronous abort of the frame in progress
//     sample_strobe : one-cycle pulse at each filter sample boundary
//     taps_flat     : active taps, tap k at [k*TAP_WIDTH +: TAP_WIDTH]
//     taps_update   : one-cycle pulse, active bank has just changed
//     load_error    : one-cycle pulse, frame rejected (short or long)
//     busy          : high while in LOAD or WAIT_SWAP
//     dbg_state     : current FSM state, for observation only
// -----------------------------------------------------------------------------
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             coef_valid,
  output logic                             coef_ready,
  input  logic [TAP_WIDTH-1:0]             coef_data,
  input  logic                             coef_last,
  input  logic                             load_abort,
  input  logic                             sample_strobe,
  output logic [TAP_COUNT*TAP_WIDTH-1:0]   taps_flat,
  output logic                             taps_update,
  output logic                             load_error,
  output logic                             busy,
  output loader_state_t                    dbg_state
);

  localparam tap_idx_t LAST_IDX = tap_idx_t'(TAP_COUNT - 1);

  loader_state_t state_q;
  loader_state_t state_d;
  tap_idx_t      index_q;
  tap_idx_t      index_d;
  logic          ready_q;
  logic          update_q;
  logic          error_q;

  logic          accept;
  logic          shadow_we;
  tap_idx_t      shadow_idx;
  logic          swap;
  logic          error_d;

  assign accept = coef_valid && ready_q;

  // ---------------------------------------------------------------------------
  // State register, index counter and registered pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      ready_q  <= 1'b1;
      update_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      ready_q  <= (state_d != ST_WAIT_SWAP);
      update_q <= swap;
      error_q  <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Abort overrides everything; in IDLE it lands on the
  // state we are already in, which makes it a no-op there.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    if (load_abort) begin
      state_d = ST_IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (coef_last) begin
              // One-beat frame is always short since TAP_COUNT >= 2.
              state_d = ST_IDLE;
              index_d = '0;
            end else begin
              state_d = ST_LOAD;
              index_d = tap_idx_t'(1);
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (coef_last && (index_q == LAST_IDX)) begin
              state_d = ST_WAIT_SWAP;
              index_d = '0;
            end else if (coef_last || (index_q == LAST_IDX)) begin
              // Short frame (last too early) or long frame (no last on the
              // final tap): drop the frame, the next beat starts a new one.
              state_d = ST_IDLE;
              index_d = '0;
            end else begin
              index_d = index_q + tap_idx_t'(1);
            end
          end
        end
        ST_WAIT_SWAP: begin
          if (sample_strobe) begin
            state_d = ST_IDLE;
            index_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          index_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: shadow write strobe, swap strobe and error cause.
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_we  = 1'b0;
    shadow_idx = index_q;
    swap       = 1'b0;
    error_d    = 1'b0;
    if (!load_abort) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shadow_we  = 1'b1;
            shadow_idx = '0;
            error_d    = coef_last;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            shadow_we = 1'b1;
            error_d   = coef_last ? (index_q != LAST_IDX) : (index_q == LAST_IDX);
          end
        end
        ST_WAIT_SWAP: begin
          swap = sample_strobe;
        end
        default: begin
          swap = 1'b0;
        end
      endcase
    end
  end

  fir_tap_bank #(
    .WIDTH     (TAP_WIDTH),
    .COUNT     (TAP_COUNT),
    .RESET_VAL (DEFAULT_TAP)
  ) u_tap_bank (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (shadow_we),
    .wr_idx    (shadow_idx),
    .wr_data   (coef_data),
    .swap      (swap),
    .taps_flat (taps_flat)
  );

  assign coef_ready  = ready_q;
  assign taps_update = update_q;
  assign load_error  = error_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_WAIT_SWAP);
  assign dbg_state   = state_q;

endmodule
